// File: rtl/csa_word_sequencer.sv
// Multi-precision add/subtract sequencer: walks one shared W-bit adder across
// WORDS words (LSW first), chaining carry through a register.
module csa_word_sequencer #(
   parameter int W      = 16,
   parameter int WORDS  = 4,
   parameter int SETTLE = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [W*WORDS-1:0] req_a,
   input  logic [W*WORDS-1:0] req_b,
   input  logic               req_sub,
   input  logic               flush,
   output logic [W-1:0]       add_a,
   output logic [W-1:0]       add_b,
   output logic               add_c_in,
   input  logic [W-1:0]       add_s,
   input  logic               add_c_out,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [W*WORDS-1:0] rsp_sum,
   output logic               rsp_c_out,
   output logic               rsp_ovf,
   output logic               busy
);
   localparam int N  = W * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [N-1:0]    res_q, res_d;
   logic            sub_q, sub_d;
   logic            carry_q, carry_d;
   logic            ovf_q, ovf_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    word_a_s;
   logic [W-1:0]    word_b_s;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, word sequencing and output decode
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      sub_d     = sub_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      add_a     = '0;
      add_b     = '0;
      add_c_in  = 1'b0;
      rsp_sum   = '0;
      rsp_c_out = 1'b0;
      rsp_ovf   = 1'b0;
      word_a_s  = a_q[idx_q*W +: W];
      word_b_s  = b_q[idx_q*W +: W] ^ {W{sub_q}};

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (flush) begin
               state_d = S_IDLE;
            end else if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               sub_d   = req_sub;
               carry_d = req_sub;
               res_d   = '0;
               ovf_d   = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            busy     = 1'b1;
            add_a    = word_a_s;
            add_b    = word_b_s;
            add_c_in = carry_q;
            if (flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == CW'(SETTLE - 1)) begin
               res_d[idx_q*W +: W] = add_s;
               carry_d = add_c_out;
               cnt_d   = '0;
               if (idx_q == IW'(WORDS - 1)) begin
                  // Sign of the top word is final only here, so overflow is captured now
                  ovf_d   = (a_q[N-1] == word_b_s[W-1]) && (add_s[W-1] != a_q[N-1]);
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
            rsp_sum   = res_q;
            rsp_c_out = carry_q;
            rsp_ovf   = ovf_q;
            if (flush) begin
               state_d = S_IDLE;
            end else if (rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_csa_word_sequencer.sv
// Scoreboard bench for csa_word_sequencer with a behavioural 16-bit adder attached.
module tb_csa_word_sequencer;
   localparam int W = 16;
   localparam int WORDS = 4;
   localparam int SETTLE = 2;
   localparam int N = W * WORDS;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [N-1:0]   req_a = '0;
   logic [N-1:0]   req_b = '0;
   logic           req_sub = 1'b0;
   logic           flush = 1'b0;
   logic [W-1:0]   add_a, add_b, add_s;
   logic           add_c_in, add_c_out;
   logic           rsp_valid;
   logic           rsp_ready = 1'b0;
   logic [N-1:0]   rsp_sum;
   logic           rsp_c_out, rsp_ovf, busy;

   typedef struct {
      logic [N-1:0]     sum;
      logic             c;
      logic             ovf;
      logic [WORDS-1:0] cin;
      logic [W-1:0]     b0;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_accepts = 0;

   csa_word_sequencer #(.W(W), .WORDS(WORDS), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .flush(flush),
      .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in), .add_s(add_s),
      .add_c_out(add_c_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_c_out(rsp_c_out), .rsp_ovf(rsp_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   // External adder the sequencer drives
   always_comb begin
      {add_c_out, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_c_in};
   end

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
      exp_t e;
      logic [N-1:0] bp;
      logic [N:0]   full;
      logic [N:0]   part;
      logic [N:0]   mask;
      bp = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bp} + {{N{1'b0}}, sub};
      e.sum = full[N-1:0];
      e.c = full[N];
      e.ovf = (a[N-1] == bp[N-1]) && (full[N-1] != a[N-1]);
      e.cin[0] = sub;
      for (int k = 1; k < WORDS; k++) begin
         mask = ({{N{1'b0}}, 1'b1} << (k * W)) - 1;
         part = ({1'b0, a} & mask) + ({1'b0, bp} & mask) + {{N{1'b0}}, sub};
         e.cin[k] = part[k * W];
      end
      e.b0 = bp[W-1:0];
      return e;
   endfunction

   task automatic check_value(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard push on accept; a flushed op is dropped
   always @(posedge clk) begin
      if (rst_n) begin
         if (flush && busy) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
         end else if (req_valid && req_ready && !flush) begin
            exp_q.push_back(model(req_a, req_b, req_sub));
            n_accepts++;
         end
      end
   end

   task automatic drive_req(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_value("req_ready_wait", {63'd0, req_ready}, 64'd1);
      req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Called right after the accept edge; returns with rsp_valid high or bound expired
   task automatic wait_rsp();
      int lat;
      logic [WORDS-1:0] cin_obs;
      logic [W-1:0] b0_obs;
      exp_t e;
      lat = 0;
      cin_obs = '0;
      cin_obs[0] = add_c_in;
      b0_obs = add_b;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if ((lat % SETTLE) == 0 && (lat / SETTLE) < WORDS) cin_obs[lat / SETTLE] = add_c_in;
      end
      check_value("latency", 64'(lat), 64'(WORDS * SETTLE));
      if (exp_q.size() > 0) begin
         e = exp_q[$];
         check_value("add_c_in_words", {60'd0, cin_obs}, {60'd0, e.cin});
         check_value("add_b_word0", {48'd0, b0_obs}, {48'd0, e.b0});
      end else begin
         check_value("scoreboard_nonempty", 64'd0, 64'd1);
      end
   endtask

   task automatic finish_op();
      exp_t e;
      if (exp_q.size() == 0) begin
         check_value("scoreboard_pop", 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         check_value("rsp_valid", {63'd0, rsp_valid}, 64'd1);
         check_value("rsp_sum", rsp_sum, e.sum);
         check_value("rsp_c_out", {63'd0, rsp_c_out}, {63'd0, e.c});
         check_value("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check_value("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
   endtask

   initial begin
      exp_t e;
      int acc0;
      #3;
      check_value("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check_value("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check_value("rst_busy", {63'd0, busy}, 64'd0);
      check_value("rst_add_a", {48'd0, add_a}, 64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      drive_req(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      wait_rsp();
      check_value("add_cin_literal", {63'd0, rsp_c_out}, 64'd1);
      finish_op();

      drive_req(64'd5, 64'd7, 1'b1);
      wait_rsp();
      check_value("sub_sum_literal", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
      finish_op();

      drive_req(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      wait_rsp();
      check_value("ovf_literal", {63'd0, rsp_ovf}, 64'd1);
      finish_op();

      // Backpressure with a pending second request
      drive_req(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
      wait_rsp();
      e = exp_q[0];
      req_a = 64'h0000_0000_0001_FFFF; req_b = 64'h0000_0000_0000_0001; req_sub = 1'b0;
      req_valid = 1'b1;
      acc0 = n_accepts;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_value("bp_rsp_sum", rsp_sum, e.sum);
         check_value("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
         check_value("bp_req_ready", {63'd0, req_ready}, 64'd0);
      end
      finish_op();
      check_value("bp_no_early_accept", 64'(n_accepts), 64'(acc0));
      check_value("bp_idle_after_hs", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_value("bp_second_accept", {63'd0, busy}, 64'd1);
      wait_rsp();
      finish_op();

      // Flush during word 2
      drive_req(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0);
      repeat (2 * SETTLE) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_value("flush_idle", {63'd0, req_ready}, 64'd1);
      check_value("flush_busy", {63'd0, busy}, 64'd0);
      check_value("flush_sb_empty", 64'(exp_q.size()), 64'd0);
      repeat (10) @(posedge clk);
      #1 check_value("flush_no_rsp", {63'd0, rsp_valid}, 64'd0);
      drive_req(64'd3, 64'd4, 1'b0);
      wait_rsp();
      check_value("post_flush_sum", rsp_sum, 64'd7);
      finish_op();

      // Flush in IDLE blocks a request
      req_a = 64'd9; req_b = 64'd9; req_sub = 1'b0; req_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      check_value("idle_flush_no_accept", {63'd0, busy}, 64'd0);

      // Asynchronous reset mid-RUN
      drive_req(64'h0123_4567_89AB_CDEF, 64'h1, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_value("arst_req_ready", {63'd0, req_ready}, 64'd1);
      check_value("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check_value("arst_add", {15'd0, add_a, add_b, add_c_in}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      repeat (12) @(posedge clk);
      #1 check_value("arst_no_stale_rsp", {63'd0, rsp_valid}, 64'd0);
      drive_req(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      wait_rsp();
      finish_op();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
